// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential N-bit ALU:
//   - 4-bit opcode map (OP_ADD .. OP_EQ), same map as the 4-bit combinational ALU
//   - handshake FSM state encoding (IDLE, BUSY, DONE)
//   - cnt_width(): width of the iteration counter for a given operand width
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_ROL  = 4'b0110;
   localparam logic [3:0] OP_ROR  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_NAND = 4'b1100;
   localparam logic [3:0] OP_XNOR = 4'b1101;
   localparam logic [3:0] OP_GT   = 4'b1110;
   localparam logic [3:0] OP_EQ   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv
//   Iterative unsigned multiplier (shift-add) and divider (restoring), one
//   step per clock, WIDTH steps per operation. The first step is taken on the
//   same edge that loads the operands, so done rises WIDTH edges after start.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         pulse: load a/b/is_div and take the first step
//   is_div        1 = divide a/b, 0 = multiply a*b
//   a, b          operands (multiplier/multiplicand or dividend/divisor)
//   done          one-cycle pulse, results valid while not restarted
//   result        low half of product, or quotient (all ones on divide by zero)
//   hi_nonzero    multiply only: high half of product is nonzero
//   div_by_zero   divide only: divisor was zero
module alu_iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             hi_nonzero,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);

   // hi: product high half / partial remainder (one guard bit)
   // lo: multiplier shifting out / quotient shifting in
   // m : multiplicand / divisor
   logic [WIDTH:0]   hi_r, hi_src, hi_nxt, sum, shifted;
   logic [WIDTH-1:0] lo_r, lo_src, lo_nxt;
   logic [WIDTH-1:0] m_r, m_src;
   logic             div_r, div_src, dbz_r;
   logic             busy;
   logic [CNT_W-1:0] cnt;

   // On start the step works on the fresh operands instead of the registers.
   always_comb begin
      hi_src  = start ? '0     : hi_r;
      lo_src  = start ? a      : lo_r;
      m_src   = start ? b      : m_r;
      div_src = start ? is_div : div_r;
      hi_nxt  = hi_src;
      lo_nxt  = lo_src;
      sum     = '0;
      shifted = '0;
      if (div_src) begin
         shifted = {hi_src[WIDTH-1:0], lo_src[WIDTH-1]};
         if (shifted >= {1'b0, m_src}) begin
            hi_nxt = shifted - {1'b0, m_src};
            lo_nxt = {lo_src[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = shifted;
            lo_nxt = {lo_src[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum = lo_src[0] ? (hi_src + {1'b0, m_src}) : hi_src;
         {hi_nxt, lo_nxt} = {1'b0, sum, lo_src[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (start || busy) begin
         hi_r <= hi_nxt;
         lo_r <= lo_nxt;
      end
      if (start) begin
         m_r   <= b;
         div_r <= is_div;
         dbz_r <= (b == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(1);
         end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   // Restoring division already yields all ones for b==0; forced for clarity.
   assign div_by_zero = div_r && dbz_r;
   assign result      = div_by_zero ? '1 : lo_r;
   assign hi_nonzero  = !div_r && (hi_r != '0);

endmodule

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit
//   Registered WIDTH-bit ALU with valid/ready handshake. Single-cycle ops are
//   computed on the accept edge; MUL/DIV use alu_iter_muldiv (WIDTH steps).
//   Result and flags are held until the consumer raises out_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   A, B, ALU_Sel       operands and 4-bit opcode
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   ALU_Out             registered result
//   Carry               carry / borrow / shift-out / MUL high half nonzero
//   Zero, Negative      result == 0, result msb
//   Overflow            signed add/sub overflow, or divide by zero
module alu_seq_nbit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             Carry,
   output logic             Zero,
   output logic             Negative,
   output logic             Overflow
);

   state_t state, state_nxt;
   logic   accept, start, is_iter, load;

   logic             md_done, md_hi_nz, md_dbz;
   logic [WIDTH-1:0] md_result;

   logic signed [WIDTH-1:0] a_s, b_s, res_s;
   logic [WIDTH:0]          sum_ext, diff_ext;
   logic [WIDTH-1:0]        alu_res, ld_res;
   logic                    alu_c, alu_v, ld_c, ld_v;

   assign is_iter = (ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV);

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_div      (ALU_Sel == OP_DIV),
      .a           (A),
      .b           (B),
      .done        (md_done),
      .result      (md_result),
      .hi_nonzero  (md_hi_nz),
      .div_by_zero (md_dbz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (is_iter) begin
                  start     = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         BUSY: if (md_done) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign a_s      = A;
   assign b_s      = B;
   assign sum_ext  = {1'b0, A} + {1'b0, B};
   assign diff_ext = {1'b0, A} - {1'b0, B};

   // Single-cycle datapath; MUL/DIV opcodes fall through to defaults.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      res_s   = '0;
      case (ALU_Sel)
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            res_s   = sum_ext[WIDTH-1:0];
            alu_v   = ((a_s < 0) == (b_s < 0)) && ((res_s < 0) != (a_s < 0));
         end
         OP_SUB: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];
            res_s   = diff_ext[WIDTH-1:0];
            alu_v   = ((a_s < 0) != (b_s < 0)) && ((res_s < 0) != (a_s < 0));
         end
         OP_SHL: begin
            alu_res = A << 1;
            alu_c   = A[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = A >> 1;
            alu_c   = A[0];
         end
         OP_ROL:  alu_res = {A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR:  alu_res = {A[0], A[WIDTH-1:1]};
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_NOR:  alu_res = ~(A | B);
         OP_NAND: alu_res = ~(A & B);
         OP_XNOR: alu_res = ~(A ^ B);
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (A > B)};
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
         default: ;
      endcase
   end

   // Output registers load either on a single-cycle accept or when the
   // iterative unit finishes.
   assign load   = (accept && !is_iter) || ((state == BUSY) && md_done);
   assign ld_res = (state == BUSY) ? md_result : alu_res;
   assign ld_c   = (state == BUSY) ? md_hi_nz  : alu_c;
   assign ld_v   = (state == BUSY) ? md_dbz    : alu_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALU_Out  <= '0;
         Carry    <= 1'b0;
         Zero     <= 1'b0;
         Negative <= 1'b0;
         Overflow <= 1'b0;
      end else if (load) begin
         ALU_Out  <= ld_res;
         Carry    <= ld_c;
         Zero     <= (ld_res == '0);
         Negative <= ld_res[WIDTH-1];
         Overflow <= ld_v;
      end
   end

endmodule

// File: tb/tb_alu_seq_nbit.sv
module tb_alu_seq_nbit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] A = 8'h00;
   logic [7:0] B = 8'h00;
   logic [3:0] ALU_Sel = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] ALU_Out;
   logic       Carry, Zero, Negative, Overflow;

   int passed = 0;
   int total  = 0;

   alu_seq_nbit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALU_Sel   (ALU_Sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALU_Out   (ALU_Out),
      .Carry     (Carry),
      .Zero      (Zero),
      .Negative  (Negative),
      .Overflow  (Overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   // Present one op (waiting for in_ready, bounded) and count edges until
   // out_valid; lat counts the accept edge as 1, -1 on timeout.
   task automatic run_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit rdy_seen);
      int w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      ALU_Sel = sel; A = a; B = b; in_valid = 1'b1;
      lat = 0; rdy_seen = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
         in_valid = 1'b0;
         if (in_ready && !out_valid) rdy_seen = 1'b1;
      end while (!out_valid && lat < 40);
      if (!out_valid) lat = -1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #3;
      total++; if (ALU_Out !== 8'h00) $display("FAIL rst_out got %h want 00", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {Carry, Zero, Negative, Overflow}); else passed++;
      total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_hs got %b want 10", {in_ready, out_valid}); else passed++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int lat; bit rs;
      run_op(4'b0000, 8'hC8, 8'h64, lat, rs);
      total++; if (lat !== 1) $display("FAIL add1_lat got %0d want 1", lat); else passed++;
      total++; if (ALU_Out !== 8'h2C) $display("FAIL add1_out got %h want 2c", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b1000) $display("FAIL add1_flags got %b want 1000", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
      run_op(4'b0000, 8'h7F, 8'h01, lat, rs);
      total++; if (ALU_Out !== 8'h80) $display("FAIL add2_out got %h want 80", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b0011) $display("FAIL add2_flags got %b want 0011", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
   endtask

   task automatic test_sub();
      int lat; bit rs;
      run_op(4'b0001, 8'h10, 8'h20, lat, rs);
      total++; if (ALU_Out !== 8'hF0) $display("FAIL sub1_out got %h want f0", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b1010) $display("FAIL sub1_flags got %b want 1010", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
      run_op(4'b0001, 8'h55, 8'h55, lat, rs);
      total++; if (ALU_Out !== 8'h00) $display("FAIL sub2_out got %h want 00", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b0100) $display("FAIL sub2_flags got %b want 0100", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
   endtask

   task automatic test_muldiv();
      int lat; bit rs;
      run_op(4'b0010, 8'd20, 8'd15, lat, rs);
      total++; if (lat !== 9) $display("FAIL mul_lat got %0d want 9", lat); else passed++;
      total++; if (rs !== 1'b0) $display("FAIL mul_inready got %b want 0", rs); else passed++;
      total++; if (ALU_Out !== 8'h2C) $display("FAIL mul_out got %h want 2c", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b1000) $display("FAIL mul_flags got %b want 1000", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
      run_op(4'b0010, 8'hFF, 8'hFF, lat, rs);
      total++; if ({ALU_Out, Carry} !== {8'h01, 1'b1}) $display("FAIL mulff_out got %h/%b want 01/1", ALU_Out, Carry); else passed++;
      consume();
      run_op(4'b0011, 8'd200, 8'd7, lat, rs);
      total++; if (lat !== 9) $display("FAIL div_lat got %0d want 9", lat); else passed++;
      total++; if (ALU_Out !== 8'h1C) $display("FAIL div_out got %h want 1c", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b0000) $display("FAIL div_flags got %b want 0000", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
      run_op(4'b0011, 8'h42, 8'h00, lat, rs);
      total++; if (lat !== 9) $display("FAIL div0_lat got %0d want 9", lat); else passed++;
      total++; if (ALU_Out !== 8'hFF) $display("FAIL div0_out got %h want ff", ALU_Out); else passed++;
      total++; if ({Carry, Zero, Negative, Overflow} !== 4'b0011) $display("FAIL div0_flags got %b want 0011", {Carry, Zero, Negative, Overflow}); else passed++;
      consume();
   endtask

   task automatic test_logic();
      // sel, a, b, expected result, expected {C,Z,N,V}
      logic [3:0] sel_t  [12] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hE, 4'hF};
      logic [7:0] a_t    [12] = '{8'h81, 8'h81, 8'h01, 8'hF0, 8'h0F, 8'hAA, 8'h00, 8'hFF, 8'hA5, 8'h80, 8'h7F, 8'h12};
      logic [7:0] b_t    [12] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'hF0, 8'hAA, 8'h00, 8'hFF, 8'h5A, 8'h7F, 8'h80, 8'h13};
      logic [7:0] res_t  [12] = '{8'h40, 8'h03, 8'h80, 8'h30, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
      logic [3:0] flg_t  [12] = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0100,
                                  4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
      int lat; bit rs;
      for (int i = 0; i < 12; i++) begin
         run_op(sel_t[i], a_t[i], b_t[i], lat, rs);
         total++;
         if ({lat, ALU_Out, Carry, Zero, Negative, Overflow} !== {32'sd1, res_t[i], flg_t[i]})
            $display("FAIL logic_%0d sel %h got lat %0d out %h flags %b want lat 1 out %h flags %b",
                     i, sel_t[i], lat, ALU_Out, {Carry, Zero, Negative, Overflow}, res_t[i], flg_t[i]);
         else passed++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      int lat; bit rs; bit bad;
      run_op(4'b0100, 8'h81, 8'h00, lat, rs);
      total++; if ({ALU_Out, Carry, Zero, Negative, Overflow} !== {8'h02, 4'b1000}) $display("FAIL shl_out got %h/%b want 02/1000", ALU_Out, {Carry, Zero, Negative, Overflow}); else passed++;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ALU_Sel = 4'b0000; A = 8'h11 + 8'(i); B = 8'h22; in_valid = 1'b1;
         @(posedge clk); #1;
         if ({out_valid, in_ready, ALU_Out, Carry, Zero, Negative, Overflow} !== {2'b10, 8'h02, 4'b1000}) bad = 1'b1;
      end
      total++; if (bad !== 1'b0) $display("FAIL hold_stable got unstable want stable"); else passed++;
      in_valid = 1'b0;
      consume();
      total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL release_hs got %b want 10", {in_ready, out_valid}); else passed++;
      @(posedge clk); #1;
      total++; if ({out_valid, ALU_Out} !== {1'b0, 8'h02}) $display("FAIL ignored_in got %b/%h want 0/02", out_valid, ALU_Out); else passed++;
   endtask

   task automatic test_reset_mid_op();
      int lat; bit rs; bit seen;
      ALU_Sel = 4'b0010; A = 8'd20; B = 8'd15; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++; if ({out_valid, ALU_Out, Carry, Zero, Negative, Overflow} !== 13'd0) $display("FAIL midrst_out got %b/%h/%b want 0/00/0000", out_valid, ALU_Out, {Carry, Zero, Negative, Overflow}); else passed++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      total++; if ({seen, in_ready} !== 2'b01) $display("FAIL midrst_abort got %b want 01", {seen, in_ready}); else passed++;
      run_op(4'b1111, 8'h33, 8'h33, lat, rs);
      total++; if ({lat, ALU_Out} !== {32'sd1, 8'h01}) $display("FAIL eq_after got %0d/%h want 1/01", lat, ALU_Out); else passed++;
      consume();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_muldiv();
      test_logic();
      test_backpressure();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
